// File: rtl/bec_la_pkg.sv
// Shared constants and types for the BEC logic-analyzer command bridge.
// Holds the field geometry, LA opcodes, LA bit positions and the bridge state enum.
package bec_la_pkg;

  localparam int unsigned FIELD_W = 163;  // GF(2^163) element width
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WORDS   = 6;    // ceil(FIELD_W / WORD_W)
  localparam int unsigned N_IN    = 5;    // key, w1, z1, w2, z2
  localparam int unsigned N_OUT   = 2;    // w, z

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // la_data_in fields
  localparam int unsigned LA_DATA_LSB = 0;
  localparam int unsigned LA_WORD_LSB = 32;
  localparam int unsigned LA_ELEM_LSB = 35;
  localparam int unsigned LA_OP_LSB   = 40;
  localparam int unsigned LA_TOG_BIT  = 42;

  // la_data_out status bits
  localparam int unsigned LA_ACK_BIT  = 32;
  localparam int unsigned LA_BUSY_BIT = 33;
  localparam int unsigned LA_DONE_BIT = 34;
  localparam int unsigned LA_ERR_BIT  = 35;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/bec_la_toggle_cmd.sv
// la_toggle_cmd: oenb-gated toggle edge detector for the LA command channel.
// A command is seen in any cycle where the toggle bit is enabled (oenb low) and differs
// from the last enabled toggle value. Field outputs are decoded straight from the LA bus so
// the command can execute at the edge ending the detect cycle.
//   clk_i, rst_i     clock, synchronous active-high reset
//   la_data_i        LA data bits [42:0] from the SoC
//   tog_oenb_i       la_oenb[42]; toggle honoured only when low
//   cmd_valid_o      one-cycle command strobe
//   cmd_tog_o        new toggle value (becomes the ack)
//   cmd_op_o/elem_o/word_o/data_o  decoded command fields
module la_toggle_cmd
  import bec_la_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [42:0] la_data_i,
  input  logic        tog_oenb_i,
  output logic        cmd_valid_o,
  output logic        cmd_tog_o,
  output logic [1:0]  cmd_op_o,
  output logic [4:0]  cmd_elem_o,
  output logic [2:0]  cmd_word_o,
  output logic [31:0] cmd_data_o
);

  logic prev_tog_q;
  logic tog_en;

  assign tog_en = ~tog_oenb_i;

  // History only advances while the toggle is driven, so a flip hidden behind oenb
  // and undone before oenb clears never registers as a command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_tog_q <= 1'b0;
    end else if (tog_en) begin
      prev_tog_q <= la_data_i[LA_TOG_BIT];
    end
  end

  assign cmd_valid_o = tog_en && (la_data_i[LA_TOG_BIT] != prev_tog_q);
  assign cmd_tog_o   = la_data_i[LA_TOG_BIT];
  assign cmd_op_o    = la_data_i[LA_OP_LSB +: 2];
  assign cmd_elem_o  = la_data_i[LA_ELEM_LSB +: 5];
  assign cmd_word_o  = la_data_i[LA_WORD_LSB +: 3];
  assign cmd_data_o  = la_data_i[LA_DATA_LSB +: 32];

endmodule

// File: rtl/bec_la_bridge.sv
// bec_la_bridge: LA-bus command bridge between the management SoC and the BEC core.
// Firmware writes operand words, starts the core, polls status and reads result words
// using a toggle/ack handshake.
//   wb_clk_i, wb_rst_i  clock, synchronous active-high reset
//   la_data_in          [31:0] data, [34:32] word, [39:35] element, [41:40] op, [42] toggle
//   la_oenb             active-low LA enables; only bit 42 is used
//   la_data_out         [31:0] read data, [32] ack, [33] busy, [34] done, [35] err
//   core_start/abort    one-cycle pulses to the core
//   core_operands       flat operand bus, element i at [i*FIELD_W +: FIELD_W]
//   core_done/result    completion pulse and result bus from the core
module bec_la_bridge
  import bec_la_pkg::*;
(
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [63:0]              la_data_in,
  input  logic [63:0]              la_oenb,
  output logic [63:0]              la_data_out,
  output logic                     core_start,
  output logic                     core_abort,
  output logic [N_IN*FIELD_W-1:0]  core_operands,
  input  logic                     core_done,
  input  logic [N_OUT*FIELD_W-1:0] core_result
);

  localparam int unsigned PadW = WORDS * WORD_W;

  logic        cmd_valid, cmd_tog;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_elem;
  logic [2:0]  cmd_word;
  logic [31:0] cmd_data;

  logic unused_la;
  assign unused_la = ^{la_oenb[63:43], la_oenb[41:0], la_data_in[63:43]};

  la_toggle_cmd u_cmd (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .la_data_i   (la_data_in[LA_TOG_BIT:0]),
    .tog_oenb_i  (la_oenb[LA_TOG_BIT]),
    .cmd_valid_o (cmd_valid),
    .cmd_tog_o   (cmd_tog),
    .cmd_op_o    (cmd_op),
    .cmd_elem_o  (cmd_elem),
    .cmd_word_o  (cmd_word),
    .cmd_data_o  (cmd_data)
  );

  state_e              state_q, state_d;
  logic [FIELD_W-1:0]  op_q  [N_IN];
  logic [FIELD_W-1:0]  op_d  [N_IN];
  logic [FIELD_W-1:0]  res_q [N_OUT];
  logic [FIELD_W-1:0]  res_d [N_OUT];
  logic                err_q, err_d, ack_q, ack_d;
  logic                start_q, start_d, abort_q, abort_d;
  logic [31:0]         rdata_q, rdata_d;

  // Word-level datapath: merge the write word into the addressed operand and pick the
  // read word out of the addressed result, both zero-padded to a whole number of words.
  logic                elem_in_ok, elem_out_ok, word_ok;
  logic [FIELD_W-1:0]  sel_op, sel_res;
  logic [PadW-1:0]     wr_ext, rd_ext;
  logic [31:0]         rd_word;
  logic                unused_wr_ext;

  assign elem_in_ok    = 32'(cmd_elem) < N_IN;
  assign elem_out_ok   = 32'(cmd_elem) < N_OUT;
  assign word_ok       = 32'(cmd_word) < WORDS;
  // Bits past FIELD_W in the top word are dropped on write.
  assign unused_wr_ext = ^wr_ext[PadW-1:FIELD_W];

  always_comb begin
    sel_op  = '0;
    sel_res = '0;
    rd_word = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (cmd_elem == 5'(i)) sel_op = op_q[i];
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (cmd_elem == 5'(i)) sel_res = res_q[i];
    end
    wr_ext = PadW'(sel_op);
    rd_ext = PadW'(sel_res);
    for (int w = 0; w < WORDS; w++) begin
      if (cmd_word == 3'(w)) begin
        wr_ext[w*WORD_W +: WORD_W] = cmd_data;
        rd_word                    = rd_ext[w*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    start_d = 1'b0;
    abort_d = 1'b0;

    // Capture first; a same-cycle CLEAR below overrides it.
    if (core_done && state_q == StBusy) begin
      for (int i = 0; i < N_OUT; i++) res_d[i] = core_result[i*FIELD_W +: FIELD_W];
      state_d = StDone;
    end

    // Commands are judged against state_q, i.e. before any same-cycle capture.
    if (cmd_valid) begin
      ack_d = cmd_tog;
      case (cmd_op)
        OP_WRITE: begin
          if (state_q == StBusy || !elem_in_ok || !word_ok) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < N_IN; i++) begin
              if (cmd_elem == 5'(i)) op_d[i] = wr_ext[FIELD_W-1:0];
            end
            if (state_q == StDone) state_d = StIdle;
          end
        end
        OP_START: begin
          if (state_q == StBusy) begin
            err_d = 1'b1;
          end else begin
            start_d = 1'b1;
            state_d = StBusy;
          end
        end
        OP_READ: begin
          if (state_q == StBusy || !elem_out_ok || !word_ok) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = rd_word;
          end
        end
        default: begin  // OP_CLEAR
          for (int i = 0; i < N_IN; i++) op_d[i] = '0;
          for (int i = 0; i < N_OUT; i++) res_d[i] = '0;
          err_d   = 1'b0;
          rdata_d = '0;
          abort_d = (state_q == StBusy);
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      for (int i = 0; i < N_IN; i++) op_q[i] <= '0;
      for (int i = 0; i < N_OUT; i++) res_q[i] <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      start_q <= start_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    la_data_out                = '0;
    la_data_out[31:0]          = rdata_q;
    la_data_out[LA_ACK_BIT]    = ack_q;
    la_data_out[LA_BUSY_BIT]   = (state_q == StBusy);
    la_data_out[LA_DONE_BIT]   = (state_q == StDone);
    la_data_out[LA_ERR_BIT]    = err_q;
    core_operands              = '0;
    for (int i = 0; i < N_IN; i++) core_operands[i*FIELD_W +: FIELD_W] = op_q[i];
  end

  assign core_start = start_q;
  assign core_abort = abort_q;

endmodule

// File: tb/tb_bec_la_bridge.sv
module tb_bec_la_bridge;
  import bec_la_pkg::*;

  typedef bit [FIELD_W-1:0] fe_t;
  localparam int MIdle = 0, MBusy = 1, MDone = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [63:0]              la_data_in, la_oenb, la_data_out;
  logic                     core_start, core_abort, core_done;
  logic [N_IN*FIELD_W-1:0]  core_operands;
  logic [N_OUT*FIELD_W-1:0] core_result;

  bec_la_bridge dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .la_data_in    (la_data_in),
    .la_oenb       (la_oenb),
    .la_data_out   (la_data_out),
    .core_start    (core_start),
    .core_abort    (core_abort),
    .core_operands (core_operands),
    .core_done     (core_done),
    .core_result   (core_result)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Reference model: what firmware should see, kept as plain element values.
  fe_t       m_ops [N_IN];
  fe_t       m_res [N_OUT];
  int        m_state;
  bit        m_err, m_ack, tog;
  bit [31:0] m_rdata;
  bit        x_start, x_abort;

  function automatic bit [63:0] exp_la();
    return {28'b0, m_err, m_state == MDone, m_state == MBusy, m_ack, m_rdata};
  endfunction

  function automatic bit [N_IN*FIELD_W-1:0] exp_ops();
    bit [N_IN*FIELD_W-1:0] r = '0;
    for (int i = 0; i < N_IN; i++) r = r | ((N_IN*FIELD_W)'(m_ops[i]) << (i * FIELD_W));
    return r;
  endfunction

  function automatic fe_t rand_fe();
    fe_t r = '0;
    for (int i = 0; i < WORDS; i++) r = (r << 32) | fe_t'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_IN; i++) m_ops[i] = '0;
    for (int i = 0; i < N_OUT; i++) m_res[i] = '0;
    m_state = MIdle; m_err = 0; m_ack = 0; m_rdata = '0; tog = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one command (optionally with a coincident core_done) and advance the model.
  task automatic send_cmd(input bit [1:0] op, input int elem, input int word,
                          input bit [31:0] data, input bit with_done, input fe_t rw, input fe_t rz);
    int pre;
    @(negedge clk);
    tog = ~tog;
    la_data_in = '0;
    la_data_in[42] = tog;
    la_data_in[41:40] = op;
    la_data_in[39:35] = 5'(elem);
    la_data_in[34:32] = 3'(word);
    la_data_in[31:0] = data;
    core_done = with_done;
    core_result = {rz, rw};
    @(posedge clk);
    #1;
    core_done = 1'b0;
    pre = m_state; x_start = 0; x_abort = 0; m_ack = tog;
    if (op == OP_CLEAR) begin
      for (int i = 0; i < N_IN; i++) m_ops[i] = '0;
      for (int i = 0; i < N_OUT; i++) m_res[i] = '0;
      m_err = 0; m_rdata = '0; m_state = MIdle; x_abort = (pre == MBusy);
    end else begin
      if (with_done && pre == MBusy) begin m_res[0] = rw; m_res[1] = rz; m_state = MDone; end
      if (op == OP_WRITE) begin
        if (pre == MBusy || elem >= int'(N_IN) || word >= int'(WORDS)) m_err = 1;
        else begin
          m_ops[elem] = (m_ops[elem] & ~(fe_t'(32'hFFFF_FFFF) << (32 * word)))
                      | (fe_t'(data) << (32 * word));
          if (pre == MDone) m_state = MIdle;
        end
      end else if (op == OP_START) begin
        if (pre == MBusy) m_err = 1;
        else begin x_start = 1; m_state = MBusy; end
      end else begin
        if (pre == MBusy || elem >= int'(N_OUT) || word >= int'(WORDS)) begin
          m_err = 1; m_rdata = '0;
        end else m_rdata = 32'(m_res[elem] >> (32 * word));
      end
    end
  endtask

  task automatic pulse_done(input fe_t rw, input fe_t rz);
    @(negedge clk);
    core_done = 1'b1;
    core_result = {rz, rw};
    @(posedge clk);
    #1;
    core_done = 1'b0;
    if (m_state == MBusy) begin m_res[0] = rw; m_res[1] = rz; m_state = MDone; end
  endtask

  task automatic test_reset();
    rst = 1'b1; la_oenb = '0; la_data_in = '0; core_done = 1'b0; core_result = '0;
    model_reset();
    tick(3);
    vectors++; if (la_data_out !== 64'h0) begin miscompares++;
      $display("FAIL reset_la got %h want %h", la_data_out, 64'h0); end
    vectors++; if (core_start !== 1'b0 || core_abort !== 1'b0) begin miscompares++;
      $display("FAIL reset_pulses got %b%b want 00", core_start, core_abort); end
    vectors++; if (core_operands !== '0) begin miscompares++;
      $display("FAIL reset_ops got %h want 0", core_operands); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write();
    send_cmd(OP_WRITE, 0, 0, 32'hDEADBEEF, 0, '0, '0);
    vectors++; if (core_operands[31:0] !== 32'hDEADBEEF) begin miscompares++;
      $display("FAIL wr_key0 got %h want deadbeef", core_operands[31:0]); end
    vectors++; if (la_data_out !== exp_la()) begin miscompares++;
      $display("FAIL wr_ack got %h want %h", la_data_out, exp_la()); end
    send_cmd(OP_WRITE, 0, 5, 32'hFFFFFFFF, 0, '0, '0);
    vectors++; if (core_operands[162:160] !== 3'b111) begin miscompares++;
      $display("FAIL wr_top got %b want 111", core_operands[162:160]); end
    vectors++; if (core_operands !== exp_ops()) begin miscompares++;
      $display("FAIL wr_trunc got %h want %h", core_operands, exp_ops()); end
    for (int k = 0; k < 20; k++) begin
      send_cmd(OP_WRITE, $urandom_range(0, N_IN - 1), $urandom_range(0, WORDS - 1),
               $urandom, 0, '0, '0);
      vectors++; if (core_operands !== exp_ops() || la_data_out !== exp_la()) begin
        miscompares++;
        $display("FAIL wr_rand ops %h la %h want ops %h la %h", core_operands, la_data_out,
                 exp_ops(), exp_la());
      end
    end
  endtask

  task automatic test_start_done();
    fe_t z = rand_fe();
    send_cmd(OP_START, 0, 0, '0, 0, '0, '0);
    vectors++; if (core_start !== 1'b1 || la_data_out !== exp_la()) begin miscompares++;
      $display("FAIL start got start=%b la=%h want 1 %h", core_start, la_data_out, exp_la()); end
    tick(1);
    vectors++; if (core_start !== 1'b0) begin miscompares++;
      $display("FAIL start_width got %b want 0", core_start); end
    tick(18);
    pulse_done(fe_t'(163'h1234), z);
    vectors++; if (la_data_out !== exp_la() || la_data_out[34:33] !== 2'b10) begin miscompares++;
      $display("FAIL done_status got %h want %h", la_data_out, exp_la()); end
    send_cmd(OP_READ, 0, 0, '0, 0, '0, '0);
    vectors++; if (la_data_out[31:0] !== 32'h00001234 || la_data_out[32] !== tog) begin
      miscompares++;
      $display("FAIL read_w0 got %h ack %b want 00001234 ack %b", la_data_out[31:0],
               la_data_out[32], tog);
    end
    for (int w = 0; w < WORDS; w++) begin
      send_cmd(OP_READ, 1, w, '0, 0, '0, '0);
      vectors++; if (la_data_out !== exp_la()) begin miscompares++;
        $display("FAIL read_z%0d got %h want %h", w, la_data_out, exp_la()); end
    end
  endtask

  task automatic test_busy_err();
    bit [N_IN*FIELD_W-1:0] saved;
    send_cmd(OP_START, 0, 0, '0, 0, '0, '0);
    vectors++; if (core_start !== 1'b1) begin miscompares++;
      $display("FAIL restart got %b want 1", core_start); end
    saved = exp_ops();
    send_cmd(OP_WRITE, 1, 0, $urandom, 0, '0, '0);
    vectors++; if (la_data_out !== exp_la() || la_data_out[35] !== 1'b1) begin miscompares++;
      $display("FAIL busy_wr_err got %h want %h", la_data_out, exp_la()); end
    vectors++; if (core_operands !== saved) begin miscompares++;
      $display("FAIL busy_wr_ops got %h want %h", core_operands, saved); end
    send_cmd(OP_READ, 0, 0, '0, 0, '0, '0);
    vectors++; if (la_data_out !== exp_la()) begin miscompares++;
      $display("FAIL busy_rd got %h want %h", la_data_out, exp_la()); end
    send_cmd(OP_CLEAR, 0, 0, '0, 0, '0, '0);
    vectors++; if (core_abort !== 1'b1 || la_data_out !== exp_la()) begin miscompares++;
      $display("FAIL clear got abort=%b la=%h want 1 %h", core_abort, la_data_out, exp_la()); end
    tick(1);
    vectors++; if (core_abort !== 1'b0 || core_operands !== '0) begin miscompares++;
      $display("FAIL clear_after got abort=%b ops=%h want 0 0", core_abort, core_operands); end
  endtask

  task automatic test_oenb();
    send_cmd(OP_WRITE, 2, 1, $urandom, 0, '0, '0);
    @(negedge clk);
    la_oenb[42] = 1'b1;
    la_data_in[41:35] = {OP_WRITE, 5'd3};
    la_data_in[31:0] = 32'hA5A5A5A5;
    la_data_in[42] = ~tog;
    tick(3);
    vectors++; if (la_data_out !== exp_la() || core_operands !== exp_ops()) begin miscompares++;
      $display("FAIL oenb_masked got %h want %h", la_data_out, exp_la()); end
    @(negedge clk); la_data_in[42] = tog;
    tick(2);
    @(negedge clk); la_oenb[42] = 1'b0;
    tick(3);
    vectors++; if (la_data_out !== exp_la() || core_operands !== exp_ops()) begin miscompares++;
      $display("FAIL oenb_release got %h want %h", la_data_out, exp_la()); end
  endtask

  task automatic test_done_clear();
    send_cmd(OP_START, 0, 0, '0, 0, '0, '0);
    tick(5);
    send_cmd(OP_CLEAR, 0, 0, '0, 1, rand_fe(), rand_fe());
    vectors++; if (la_data_out !== exp_la() || core_abort !== 1'b1) begin miscompares++;
      $display("FAIL done_clear got %h abort %b want %h 1", la_data_out, core_abort, exp_la()); end
    send_cmd(OP_READ, 0, 0, '0, 0, '0, '0);
    vectors++; if (la_data_out !== exp_la()) begin miscompares++;
      $display("FAIL done_clear_rd got %h want %h", la_data_out, exp_la()); end
    send_cmd(OP_START, 0, 0, '0, 0, '0, '0);
    tick(3);
    send_cmd(OP_WRITE, 0, 0, $urandom, 1, rand_fe(), rand_fe());
    vectors++; if (la_data_out !== exp_la() || core_operands !== exp_ops()) begin miscompares++;
      $display("FAIL done_write got %h want %h", la_data_out, exp_la()); end
    send_cmd(OP_READ, 1, 2, '0, 0, '0, '0);
    vectors++; if (la_data_out !== exp_la()) begin miscompares++;
      $display("FAIL done_write_rd got %h want %h", la_data_out, exp_la()); end
  endtask

  task automatic test_reset_mid();
    send_cmd(OP_START, 0, 0, '0, 0, '0, '0);
    tick(4);
    @(negedge clk);
    rst = 1'b1; la_data_in = '0;
    model_reset();
    tick(1);
    vectors++; if (la_data_out !== 64'h0) begin miscompares++;
      $display("FAIL rst_mid got %h want 0", la_data_out); end
    @(negedge clk); rst = 1'b0;
    pulse_done(rand_fe(), rand_fe());
    vectors++; if (la_data_out !== exp_la()) begin miscompares++;
      $display("FAIL rst_late_done got %h want %h", la_data_out, exp_la()); end
    send_cmd(OP_READ, 0, 0, '0, 0, '0, '0);
    vectors++; if (la_data_out !== exp_la()) begin miscompares++;
      $display("FAIL rst_rd got %h want %h", la_data_out, exp_la()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      int r = $urandom_range(0, 19);
      bit [1:0] op;
      if (r < 2 && m_state == MBusy) begin
        pulse_done(rand_fe(), rand_fe());
        x_start = 0; x_abort = 0;
      end else begin
        op = (r < 3) ? OP_CLEAR : (r < 7) ? OP_START : (r < 13) ? OP_READ : OP_WRITE;
        send_cmd(op, $urandom_range(0, 6), $urandom_range(0, 7), $urandom,
                 (m_state == MBusy) && ($urandom_range(0, 3) == 0), rand_fe(), rand_fe());
      end
      vectors++;
      if (la_data_out !== exp_la() || core_operands !== exp_ops() ||
          core_start !== x_start || core_abort !== x_abort) begin
        miscompares++;
        $display("FAIL rand%0d la %h st %b ab %b want la %h st %b ab %b", k, la_data_out,
                 core_start, core_abort, exp_la(), x_start, x_abort);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_start_done();
    test_busy_err();
    test_oenb();
    test_done_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
